// File: rtl/tb_scoreboard_pkg.sv
// Shared helpers for the check scoreboard: index width and saturating counter math.
package tb_scoreboard_pkg;

  // Widest counter supported; narrower counters clamp through the lim argument.
  localparam int SAT_W = 32;
  typedef logic [SAT_W-1:0] sat_cnt_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic sat_cnt_t sat_add(input sat_cnt_t cnt, input sat_cnt_t inc,
                                       input sat_cnt_t lim = '1);
    logic [SAT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/tb_scoreboard_fifo.sv
// Per-channel expected-value FIFO; pointers carry a wrap bit so full/empty compare MSBs.
module tb_scoreboard_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp_q, rp_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head_o  = mem_q[rp_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/tb_scoreboard.sv
// Multi-channel check scoreboard: expected FIFOs, pass/fail tallies, first-fail capture, halt.
// Define TB_SCOREBOARD_PERCH_EN to add per-channel saturating fail counters (ch_fail_count).
module tb_scoreboard
  import tb_scoreboard_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCH-1:0]               exp_valid,
  input  logic [NCH*WIDTH-1:0]         exp_data,
  output logic [NCH-1:0]               exp_ready,
  input  logic [NCH-1:0]               act_valid,
  input  logic [NCH*WIDTH-1:0]         act_data,
  input  logic                         die_on_fail,
  output logic [NCH-1:0]               chk_pass,
  output logic [NCH-1:0]               chk_fail,
  output logic [CNTW-1:0]              tot_count,
  output logic [CNTW-1:0]              pass_count,
  output logic [CNTW-1:0]              fail_count,
`ifdef TB_SCOREBOARD_PERCH_EN
  output logic [NCH*CNTW-1:0]          ch_fail_count,
`endif
  output logic                         first_fail_valid,
  output logic [clog2_min1(NCH)-1:0]   first_fail_ch,
  output logic [WIDTH-1:0]             first_fail_exp,
  output logic [WIDTH-1:0]             first_fail_act,
  output logic                         underflow,
  output logic                         halt
);
  localparam int       CHW  = clog2_min1(NCH);
  localparam sat_cnt_t CMAX = sat_cnt_t'((64'd1 << CNTW) - 64'd1);

  logic [NCH-1:0]            empty, full, pass_c, fail_c;
  logic [NCH-1:0][WIDTH-1:0] head;
  sat_cnt_t                  n_act, n_pass, n_fail;
  logic [CHW-1:0]            ff_ch;
  logic [WIDTH-1:0]          ff_exp, ff_act;

  logic [NCH-1:0]   pass_q, fail_q;
  logic [CNTW-1:0]  tot_q, pc_q, fc_q;
  logic             ffv_q, uf_q, halt_q;
  logic [CHW-1:0]   ffch_q;
  logic [WIDTH-1:0] ffexp_q, ffact_q;

  assign exp_ready = ~full;

  // Pop and compare use the registered head only, so a same-cycle push never bypasses.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tb_scoreboard_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (exp_valid[g] & ~full[g]),
      .din_i   (exp_data[g*WIDTH +: WIDTH]),
      .pop_i   (act_valid[g]),
      .head_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
    assign pass_c[g] = act_valid[g] & ~empty[g] & (head[g] == act_data[g*WIDTH +: WIDTH]);
    assign fail_c[g] = act_valid[g] & ~pass_c[g];
  end

  always_comb begin
    n_act  = '0;
    n_pass = '0;
    n_fail = '0;
    ff_ch  = '0;
    ff_exp = '0;
    ff_act = '0;
    for (int i = 0; i < NCH; i++) begin
      n_act  = n_act  + sat_cnt_t'(act_valid[i]);
      n_pass = n_pass + sat_cnt_t'(pass_c[i]);
      n_fail = n_fail + sat_cnt_t'(fail_c[i]);
    end
    // Descending scan so the lowest failing channel is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fail_c[i]) begin
        ff_ch  = CHW'(i);
        ff_exp = empty[i] ? '0 : head[i];
        ff_act = act_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q  <= '0;
      fail_q  <= '0;
      tot_q   <= '0;
      pc_q    <= '0;
      fc_q    <= '0;
      ffv_q   <= 1'b0;
      ffch_q  <= '0;
      ffexp_q <= '0;
      ffact_q <= '0;
      uf_q    <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      pass_q <= pass_c;
      fail_q <= fail_c;
      tot_q  <= CNTW'(sat_add(sat_cnt_t'(tot_q), n_act, CMAX));
      pc_q   <= CNTW'(sat_add(sat_cnt_t'(pc_q), n_pass, CMAX));
      fc_q   <= CNTW'(sat_add(sat_cnt_t'(fc_q), n_fail, CMAX));
      if (|fail_c && !ffv_q) begin
        ffv_q   <= 1'b1;
        ffch_q  <= ff_ch;
        ffexp_q <= ff_exp;
        ffact_q <= ff_act;
      end
      if (|(act_valid & empty))   uf_q   <= 1'b1;
      if (die_on_fail && |fail_c) halt_q <= 1'b1;
    end
  end

`ifdef TB_SCOREBOARD_PERCH_EN
  logic [NCH-1:0][CNTW-1:0] chf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chf_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        chf_q[i] <= CNTW'(sat_add(sat_cnt_t'(chf_q[i]), sat_cnt_t'(fail_c[i]), CMAX));
    end
  end

  assign ch_fail_count = chf_q;
`endif

  assign chk_pass         = pass_q;
  assign chk_fail         = fail_q;
  assign tot_count        = tot_q;
  assign pass_count       = pc_q;
  assign fail_count       = fc_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_ch    = ffch_q;
  assign first_fail_exp   = ffexp_q;
  assign first_fail_act   = ffact_q;
  assign underflow        = uf_q;
  assign halt             = halt_q;

endmodule

// File: tb/tb_tb_scoreboard.sv
// Self-checking bench for tb_scoreboard: directed table, corner sequences, randomized model run.
module tb_tb_scoreboard;
  localparam int NCH = 2, WIDTH = 8, DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  exp_valid, act_valid;
  logic [15:0] exp_data, act_data;
  logic        die_on_fail;

  logic [1:0]  exp_ready, chk_pass, chk_fail;
  logic [15:0] tot_count, pass_count, fail_count;
  logic        ffv, underflow, halt;
  logic [0:0]  ffch;
  logic [7:0]  ffexp, ffact;

  logic [1:0]  s_ready, s_pass, s_fail;
  logic [3:0]  s_tot, s_pc, s_fc;
  logic        s_ffv, s_uf, s_halt;
  logic [0:0]  s_ffch;
  logic [7:0]  s_ffe, s_ffa;
`ifdef TB_SCOREBOARD_PERCH_EN
  logic [31:0] chfc;
  logic [7:0]  s_chfc;
`endif

  tb_scoreboard #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(16)) u_dut (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(exp_ready), .act_valid(act_valid), .act_data(act_data),
    .die_on_fail(die_on_fail), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .tot_count(tot_count), .pass_count(pass_count), .fail_count(fail_count),
`ifdef TB_SCOREBOARD_PERCH_EN
    .ch_fail_count(chfc),
`endif
    .first_fail_valid(ffv), .first_fail_ch(ffch), .first_fail_exp(ffexp),
    .first_fail_act(ffact), .underflow(underflow), .halt(halt)
  );

  // Narrow-counter copy on the same inputs, for saturation behaviour.
  tb_scoreboard #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(4)) u_sat (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(s_ready), .act_valid(act_valid), .act_data(act_data),
    .die_on_fail(die_on_fail), .chk_pass(s_pass), .chk_fail(s_fail),
    .tot_count(s_tot), .pass_count(s_pc), .fail_count(s_fc),
`ifdef TB_SCOREBOARD_PERCH_EN
    .ch_fail_count(s_chfc),
`endif
    .first_fail_valid(s_ffv), .first_fail_ch(s_ffch), .first_fail_exp(s_ffe),
    .first_fail_act(s_ffa), .underflow(s_uf), .halt(s_halt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint a, input longint e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, a, e, $time);
    end
  endtask

  // Reference model: queues of expected values and plain integer tallies.
  logic [7:0] q[NCH][$];
  int   m_tot, m_pass, m_fail, m_chf[NCH];
  bit   m_ffv, m_uf, m_halt;
  int   m_ffch;
  logic [7:0] m_ffe, m_ffa;
  logic [1:0] m_p, m_f;

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      m_chf[c] = 0;
    end
    m_tot = 0; m_pass = 0; m_fail = 0;
    m_ffv = 0; m_uf = 0; m_halt = 0; m_ffch = 0; m_ffe = 0; m_ffa = 0;
    m_p = '0; m_f = '0;
  endtask

  task automatic do_reset();
    exp_valid = '0; act_valid = '0; exp_data = '0; act_data = '0; die_on_fail = 1'b0;
    reset = 1'b1;
    #3;
    chk("rst_ready", exp_ready, 2'b11);
    chk("rst_tot", tot_count, 0);
    chk("rst_ffv", ffv, 0);
    chk("rst_halt", halt, 0);
    chk("rst_fail_strobe", chk_fail, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // One clock: predict from the current inputs, step, compare every observable.
  task automatic cycle();
    int sz[NCH];
    logic [7:0] e, a;
    logic [1:0] rdy;
    m_p = '0; m_f = '0;
    for (int c = 0; c < NCH; c++) sz[c] = q[c].size();
    rdy = {sz[1] < DEPTH, sz[0] < DEPTH};
    chk("exp_ready", exp_ready, rdy);
    for (int c = 0; c < NCH; c++) begin
      if (act_valid[c]) begin
        a = act_data[c*8 +: 8];
        if (sz[c] == 0) begin
          e = 8'h00; m_f[c] = 1'b1; m_uf = 1;
        end else begin
          e = q[c].pop_front();
          if (e == a) m_p[c] = 1'b1; else m_f[c] = 1'b1;
        end
        if (m_f[c]) begin
          m_chf[c]++;
          if (!m_ffv) begin m_ffv = 1; m_ffch = c; m_ffe = e; m_ffa = a; end
        end
      end
    end
    for (int c = 0; c < NCH; c++)
      if (exp_valid[c] && sz[c] < DEPTH) q[c].push_back(exp_data[c*8 +: 8]);
    m_tot  += $countones(act_valid);
    m_pass += $countones(m_p);
    m_fail += $countones(m_f);
    if (die_on_fail && m_f != 0) m_halt = 1;
    @(posedge clk);
    #1;
    chk("chk_pass", chk_pass, m_p);
    chk("chk_fail", chk_fail, m_f);
    chk("tot", tot_count, m_tot);
    chk("pass", pass_count, m_pass);
    chk("fail", fail_count, m_fail);
    chk("sat_tot", s_tot, sat15(m_tot));
    chk("sat_pass", s_pc, sat15(m_pass));
    chk("sat_fail", s_fc, sat15(m_fail));
    chk("ff_valid", ffv, m_ffv);
    if (m_ffv) begin
      chk("ff_ch", ffch, m_ffch);
      chk("ff_exp", ffexp, m_ffe);
      chk("ff_act", ffact, m_ffa);
    end
    chk("underflow", underflow, m_uf);
    chk("halt", halt, m_halt);
`ifdef TB_SCOREBOARD_PERCH_EN
    chk("ch_fail0", chfc[15:0], m_chf[0]);
    chk("ch_fail1", chfc[31:16], m_chf[1]);
`endif
  endtask

  typedef struct {
    logic [1:0]  ev;
    logic [15:0] ed;
    logic [1:0]  av;
    logic [15:0] ad;
    logic [1:0]  ep, ef;
    int          tot, pc, fc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{2'b01, 16'h0011, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0};
    tbl[1] = '{2'b01, 16'h0022, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 0, 0};
    tbl[2] = '{2'b00, 16'h0000, 2'b01, 16'h0011, 2'b01, 2'b00, 1, 1, 0};
    tbl[3] = '{2'b00, 16'h0000, 2'b01, 16'h0022, 2'b01, 2'b00, 2, 2, 0};
    tbl[4] = '{2'b10, 16'h5A00, 2'b00, 16'h0000, 2'b00, 2'b00, 2, 2, 0};
    tbl[5] = '{2'b00, 16'h0000, 2'b10, 16'hA500, 2'b00, 2'b10, 3, 2, 1};
    tbl[6] = '{2'b10, 16'h3300, 2'b00, 16'h0000, 2'b00, 2'b00, 3, 2, 1};
    tbl[7] = '{2'b00, 16'h0000, 2'b10, 16'h4400, 2'b00, 2'b10, 4, 2, 2};

    reset = 1'b1;
    do_reset();

    // Basic pass and mismatch/capture, from the table.
    for (int i = 0; i < 8; i++) begin
      exp_valid = tbl[i].ev; exp_data = tbl[i].ed;
      act_valid = tbl[i].av; act_data = tbl[i].ad;
      chk("tbl_ready", exp_ready, 2'b11);
      @(posedge clk);
      #1;
      chk("tbl_pass", chk_pass, tbl[i].ep);
      chk("tbl_fail", chk_fail, tbl[i].ef);
      chk("tbl_tot", tot_count, tbl[i].tot);
      chk("tbl_passcnt", pass_count, tbl[i].pc);
      chk("tbl_failcnt", fail_count, tbl[i].fc);
    end
    chk("cap_valid", ffv, 1);
    chk("cap_ch", ffch, 1);
    chk("cap_exp", ffexp, 8'h5A);
    chk("cap_act", ffact, 8'hA5);
    chk("cap_halt", halt, 0);
    chk("cap_uf", underflow, 0);

    // Simultaneous fails: both channels at once, lowest index captured.
    do_reset();
    exp_valid = 2'b11; exp_data = 16'h7766; cycle();
    exp_valid = 2'b00; act_valid = 2'b11; act_data = 16'h0000; cycle();
    chk("sim_fail_cnt", fail_count, 2);
    chk("sim_ff_ch", ffch, 0);
    chk("sim_ff_exp", ffexp, 8'h66);

    // Full FIFO, dropped 9th push, underflow on empty channel.
    do_reset();
    act_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      exp_valid = 2'b01; exp_data = 16'(k + 1); cycle();
    end
    chk("full_ready0", exp_ready[0], 0);
    exp_data = 16'h0099; cycle();
    exp_valid = 2'b00; act_valid = 2'b10; act_data = 16'h1200; cycle();
    chk("uf_flag", underflow, 1);
    chk("uf_ff_exp", ffexp, 0);
    chk("uf_ff_ch", ffch, 1);
    for (int k = 0; k < 8; k++) begin
      act_valid = 2'b01; act_data = 16'(k + 1); cycle();
    end
    act_data = 16'h0099; cycle();
    chk("drop9_fail", chk_fail, 2'b01);
    act_valid = 2'b00;

    // Halt is sticky, then an asynchronous reset mid-cycle clears everything.
    do_reset();
    die_on_fail = 1'b1;
    exp_valid = 2'b01; exp_data = 16'h0010; cycle();
    exp_valid = 2'b00; act_valid = 2'b01; act_data = 16'h0011; cycle();
    chk("halt_set", halt, 1);
    die_on_fail = 1'b0; act_valid = 2'b00;
    for (int k = 0; k < 3; k++) cycle();
    chk("halt_sticky", halt, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_halt", halt, 0);
    chk("arst_tot", tot_count, 0);
    chk("arst_fail", fail_count, 0);
    chk("arst_ffv", ffv, 0);
    chk("arst_ready", exp_ready, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Saturation on the 4-bit instance.
    do_reset();
    exp_valid = 2'b01; exp_data = 16'd1; cycle();
    for (int k = 1; k <= 20; k++) begin
      exp_data = 16'(k + 1); act_valid = 2'b01; act_data = 16'(k); cycle();
    end
    chk("sat_tot15", s_tot, 15);
    chk("sat_pass15", s_pc, 15);
    chk("sat_fail0", s_fc, 0);
    chk("wide_tot20", tot_count, 20);
    exp_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      act_valid = 2'b10; act_data = 16'h0000; cycle();
    end
`ifdef TB_SCOREBOARD_PERCH_EN
    chk("perch_ch1", s_chfc[7:4], 3);
    chk("perch_ch0", s_chfc[3:0], 0);
`endif
    act_valid = 2'b00;

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      exp_valid   = 2'($urandom_range(0, 3));
      act_valid   = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
      exp_data    = 16'($urandom_range(0, 65535));
      act_data    = 16'($urandom_range(0, 65535));
      die_on_fail = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NCH; c++)
        if (q[c].size() != 0 && $urandom_range(0, 3) != 0) act_data[c*8 +: 8] = q[c][0];
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
